// File: rtl/if_gshare_pkg.sv
// Shared decode constants and branch-queue entry layout for the fetch-PC
// generator and its in-flight branch queue.
package if_gshare_pkg;

   localparam logic [6:0] BRANCHOP = 7'b1100011;
   localparam logic [6:0] JALOP    = 7'b1101111;
   localparam logic [6:0] JALROP   = 7'b1100111;

   // Weakly not-taken, so a cold branch falls through.
   localparam logic [1:0] CTR_RESET = 2'b01;

   // Queue entry is {idx, pred}: prediction in the LSB, BHT index above it.
   localparam int BQE_PRED_BIT = 0;

   typedef enum logic [1:0] {
      INS_OTHER,
      INS_BRANCH,
      INS_JAL,
      INS_JALR
   } ins_kind_e;

   function automatic ins_kind_e decode_kind(input logic [6:0] op);
      case (op)
         BRANCHOP: return INS_BRANCH;
         JALOP:    return INS_JAL;
         JALROP:   return INS_JALR;
         default:  return INS_OTHER;
      endcase
   endfunction

endpackage

// File: rtl/if_branch_queue.sv
// Power-of-two circular FIFO holding in-flight branch predictions until the
// ROB retires them; clear drops every entry in one cycle.
module if_branch_queue #(
   parameter int W     = 7,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [W-1:0]             push_data,
   input  logic                     pop,
   input  logic                     clear,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic [W-1:0]             head_data
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] CAP = CNT_W'(DEPTH);

   logic [DEPTH-1:0][W-1:0] mem;
   logic [PTR_W-1:0]        head, tail;
   logic [CNT_W-1:0]        cnt;
   logic                    do_push, do_pop;

   assign full      = (cnt == CAP);
   assign empty     = (cnt == '0);
   assign count     = cnt;
   assign head_data = mem[head];

   // Full/empty come from the registered count, so a pop never frees a slot
   // for a push in the same cycle.
   assign do_push = push & ~full & ~clear;
   assign do_pop  = pop & ~empty & ~clear;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head <= '0;
         tail <= '0;
         cnt  <= '0;
      end else if (clear) begin
         head <= '0;
         tail <= '0;
         cnt  <= '0;
      end else begin
         if (do_push) tail <= tail + 1'b1;
         if (do_pop)  head <= head + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[tail] <= push_data;
   end

endmodule

// File: rtl/if_gshare.sv
// Fetch-PC generator: predicts the next PC from the fetched instruction with a
// gshare/bimodal BHT, tracks branches in flight and recovers on flush.
module if_gshare
   import if_gshare_pkg::*;
#(
   parameter int          BHT_IDX_W = 6,
   parameter int          GHR_W     = 6,
   parameter int          BQ_DEPTH  = 16,
   parameter int          PRED_MODE = 1,
   parameter logic [31:0] RESET_PC  = 32'h0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rdy,
   input  logic        br_commit,
   input  logic        br_taken,
   input  logic        flush,
   input  logic [31:0] flush_pc,
   input  logic        stall_id,
   output logic        ins_valid_id,
   output logic [31:0] ins_id,
   output logic        pred_taken_id,
   output logic [31:0] alt_pc_id,
   input  logic        ins_valid,
   input  logic [31:0] ins,
   output logic [31:0] pc_out,
   output logic [31:0] hit_cnt,
   output logic [31:0] miss_cnt
);
   localparam int BHT_N = 1 << BHT_IDX_W;
   localparam int BQE_W = BHT_IDX_W + 1;
   localparam int BQC_W = $clog2(BQ_DEPTH) + 1;

   logic [31:0]           pc, npc, imm_b, imm_j, pc_seq, pc_br, pc_jal;
   logic [BHT_N-1:0][1:0] bht;
   logic [GHR_W-1:0]      spec_ghr, ret_ghr, ret_ghr_nxt;
   logic [BHT_IDX_W-1:0]  ghr_ext, pidx, h_idx;
   logic                  pred, h_pred, is_branch, acc, cmt;
   logic                  bq_push, bq_clear, bq_full, bq_empty;
   logic [BQE_W-1:0]      bq_head;
   logic [BQC_W-1:0]      bq_count_unused;
   logic [1:0]            ctr_cur, ctr_nxt;
   ins_kind_e             kind;

   function automatic logic [GHR_W-1:0] ghr_shift(input logic [GHR_W-1:0] g,
                                                  input logic b);
      return (g << 1) | GHR_W'(b);
   endfunction

   assign kind      = decode_kind(ins[6:0]);
   assign is_branch = (kind == INS_BRANCH);

   assign imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
   assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

   assign pc_seq = pc + 32'd4;
   assign pc_br  = pc + imm_b;
   assign pc_jal = pc + imm_j;

   // History is narrower than (or equal to) the index; pad it with zeros.
   always_comb begin
      ghr_ext = '0;
      ghr_ext[GHR_W-1:0] = spec_ghr;
   end

   assign pidx = pc[BHT_IDX_W+1:2] ^ ((PRED_MODE != 0) ? ghr_ext : '0);
   assign pred = bht[pidx][1];

   always_comb begin
      npc           = pc_seq;
      alt_pc_id     = pc_seq;
      pred_taken_id = 1'b0;
      case (kind)
         INS_BRANCH: begin
            pred_taken_id = pred;
            npc           = pred ? pc_br : pc_seq;
            alt_pc_id     = pred ? pc_seq : pc_br;
         end
         INS_JAL: begin
            pred_taken_id = 1'b1;
            npc           = pc_jal;
         end
         default: ;
      endcase
   end

   assign acc          = rdy & ins_valid & ~stall_id & ~flush & ~(is_branch & bq_full);
   assign ins_valid_id = acc;
   assign ins_id       = ins;
   assign pc_out       = acc ? npc : pc;

   assign cmt      = rdy & br_commit & ~bq_empty;
   assign bq_push  = acc & is_branch;
   assign bq_clear = rdy & flush;

   if_branch_queue #(
      .W     (BQE_W),
      .DEPTH (BQ_DEPTH)
   ) u_bq (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (bq_push),
      .push_data ({pidx, pred}),
      .pop       (cmt),
      .clear     (bq_clear),
      .full      (bq_full),
      .empty     (bq_empty),
      .count     (bq_count_unused),
      .head_data (bq_head)
   );

   assign h_idx  = bq_head[BQE_W-1:BQE_PRED_BIT+1];
   assign h_pred = bq_head[BQE_PRED_BIT];

   assign ctr_cur     = bht[h_idx];
   assign ret_ghr_nxt = ghr_shift(ret_ghr, br_taken);

   always_comb begin
      ctr_nxt = ctr_cur;
      if (br_taken && ctr_cur != 2'b11)
         ctr_nxt = ctr_cur + 2'd1;
      else if (!br_taken && ctr_cur != 2'b00)
         ctr_nxt = ctr_cur - 2'd1;
   end

   // Flush restores speculative history from the retired one, folding in a
   // branch that commits on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc       <= RESET_PC;
         spec_ghr <= '0;
         ret_ghr  <= '0;
      end else if (rdy) begin
         if (flush) begin
            pc       <= flush_pc;
            spec_ghr <= cmt ? ret_ghr_nxt : ret_ghr;
         end else if (acc) begin
            pc <= npc;
            if (is_branch) spec_ghr <= ghr_shift(spec_ghr, pred);
         end
         if (cmt) ret_ghr <= ret_ghr_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bht      <= {BHT_N{CTR_RESET}};
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else if (cmt) begin
         bht[h_idx] <= ctr_nxt;
         if (h_pred == br_taken) hit_cnt  <= hit_cnt + 32'd1;
         else                    miss_cnt <= miss_cnt + 32'd1;
      end
   end

endmodule
